// File: rtl/mips_main_control_fsm.sv
// Main control FSM of the multi-cycle MIPS core. It sequences fetch/decode/execute/memory/writeback
// over the shared datapath and drives every enable, mux select and the ALUOp code.
module mips_main_control_fsm #(
    parameter bit          MEM_WAIT_EN = 1'b1,
    parameter int unsigned STATE_W     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] pc_source_o,
    output logic [2:0] alu_op_o,
    output logic       illegal_o
);

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnJalr = 6'b001001;

    localparam logic [2:0] AluAdd   = 3'b000;
    localparam logic [2:0] AluSub   = 3'b001;
    localparam logic [2:0] AluFunct = 3'b010;
    localparam logic [2:0] AluSlt   = 3'b011;
    localparam logic [2:0] AluAnd   = 3'b100;
    localparam logic [2:0] AluOr    = 3'b101;
    localparam logic [2:0] AluXor   = 3'b110;

    typedef enum logic [STATE_W-1:0] {
        StInit,
        StFetch,
        StDecode,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StRExec,
        StRWb,
        StJr,
        StIExec,
        StIWb,
        StBranch,
        StJump,
        StJal
    } state_e;

    // fetch/decode are internal flags: fetch gates PCWrite/IRWrite with MemReady,
    // decode qualifies the Illegal pulse.
    typedef struct packed {
        logic       fetch;
        logic       decode;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       ready;

    function automatic logic is_legal(input logic [5:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            OpLw, OpSw, OpRType, OpBeq, OpBne, OpJ, OpJal,
            OpAddi, OpAndi, OpOri, OpXori, OpSlti: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] aop;
        aop = AluAdd;
        case (op)
            OpAndi:  aop = AluAnd;
            OpOri:   aop = AluOr;
            OpXori:  aop = AluXor;
            OpSlti:  aop = AluSlt;
            default: aop = AluAdd;
        endcase
        return aop;
    endfunction

    // Output image of a state; op/fn are the latched values that state will see.
    function automatic ctrl_t decode_ctrl(input state_e st, input logic [5:0] op,
                                          input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: begin
                c.decode    = 1'b1;
                c.alu_src_b = 2'b11;
            end
            StMemAddr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRead: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
            end
            StMemWrite: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            StRExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = AluFunct;
            end
            StRWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            StJr: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
                if (fn == FnJalr) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = 2'b01;
                    c.mem_to_reg = 2'b10;
                end
            end
            StIExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = imm_alu_op(op);
            end
            StIWb: begin
                c.reg_write = 1'b1;
                c.alu_op    = imm_alu_op(op);
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = AluSub;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.branch_ne     = (op == OpBne);
            end
            StJump: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            StJal: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            StInit:  state_d = StFetch;
            StFetch: if (ready) state_d = StDecode;
            StDecode: begin
                op_d = opcode_i;
                case (opcode_i)
                    OpLw, OpSw:                              state_d = StMemAddr;
                    OpRType:                                 state_d = StRExec;
                    OpBeq, OpBne:                            state_d = StBranch;
                    OpJ:                                     state_d = StJump;
                    OpJal:                                   state_d = StJal;
                    OpAddi, OpAndi, OpOri, OpXori, OpSlti:   state_d = StIExec;
                    default:                                 state_d = StFetch;
                endcase
            end
            StMemAddr:  state_d = (op_q == OpLw) ? StMemRead : StMemWrite;
            StMemRead:  if (ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (ready) state_d = StFetch;
            StRExec: begin
                funct_d = funct_i;
                state_d = (funct_i == FnJr || funct_i == FnJalr) ? StJr : StRWb;
            end
            StRWb:    state_d = StFetch;
            StJr:     state_d = StFetch;
            StIExec:  state_d = StIWb;
            StIWb:    state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StJal:    state_d = StFetch;
            default:  state_d = StInit;
        endcase
        ctrl_d = decode_ctrl(state_d, op_d, funct_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            ctrl_q  <= '0;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    assign pc_write_o      = ctrl_q.pc_write | (ctrl_q.fetch & ready);
    assign ir_write_o      = ctrl_q.fetch & ready;
    assign illegal_o       = ctrl_q.decode & ~is_legal(opcode_i);
    assign pc_write_cond_o = ctrl_q.pc_write_cond;
    assign branch_ne_o     = ctrl_q.branch_ne;
    assign iord_o          = ctrl_q.iord;
    assign mem_read_o      = ctrl_q.mem_read;
    assign mem_write_o     = ctrl_q.mem_write;
    assign reg_write_o     = ctrl_q.reg_write;
    assign reg_dst_o       = ctrl_q.reg_dst;
    assign mem_to_reg_o    = ctrl_q.mem_to_reg;
    assign alu_src_a_o     = ctrl_q.alu_src_a;
    assign alu_src_b_o     = ctrl_q.alu_src_b;
    assign pc_source_o     = ctrl_q.pc_source;
    assign alu_op_o        = ctrl_q.alu_op;

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Bench for mips_main_control_fsm: per-instruction cycle sequences built from the instruction
// semantics, driven with random opcodes, functs and memory wait lengths.
module tb_mips_main_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic       reg_write, alu_src_a, illegal;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r;
        logic       srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       ill;
    } ctl_t;

    ctl_t obs;
    assign obs = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
                  illegal};

    mips_main_control_fsm dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .opcode_i        (opcode),
        .funct_i         (funct),
        .mem_ready_i     (mem_ready),
        .pc_write_o      (pc_write),
        .pc_write_cond_o (pc_write_cond),
        .branch_ne_o     (branch_ne),
        .iord_o          (iord),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .ir_write_o      (ir_write),
        .reg_write_o     (reg_write),
        .reg_dst_o       (reg_dst),
        .mem_to_reg_o    (mem_to_reg),
        .alu_src_a_o     (alu_src_a),
        .alu_src_b_o     (alu_src_b),
        .pc_source_o     (pc_source),
        .alu_op_o        (alu_op),
        .illegal_o       (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [5:0] legal_ops [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                   6'b000010, 6'b000011, 6'b001000, 6'b001100, 6'b001101,
                                   6'b001110, 6'b001010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] g6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle's inputs after the falling edge and compare the full control word.
    task automatic cyc(input string tag, input ctl_t e, input logic rdy, input logic [5:0] op,
                       input logic [5:0] fn);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        funct     = fn;
        #1;
        check(tag, 32'(obs), 32'(e));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(obs), 32'd0);
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst_hold", 32'(obs), 32'd0);
        rst_n = 1'b1;
        #1;
        check("init", 32'(obs), 32'd0);
    endtask

    task automatic do_fetch(input int waits);
        ctl_t e;
        for (int i = 0; i <= waits; i++) begin
            e       = '0;
            e.mrd   = 1'b1;
            e.srcb  = 2'b01;
            e.irw   = (i == waits);
            e.pcw   = (i == waits);
            cyc("fetch", e, i == waits, g6(), g6());
        end
    endtask

    task automatic do_decode(input logic [5:0] op);
        ctl_t e;
        e      = '0;
        e.srcb = 2'b11;
        e.ill  = ~is_legal(op);
        cyc("decode", e, 1'($urandom_range(0, 1)), op, g6());
    endtask

    task automatic do_exec(input logic [5:0] op, input logic [5:0] fn, input int mwaits);
        ctl_t e;
        logic [2:0] iop;
        e = '0;
        case (op)
            6'b100011, 6'b101011: begin
                e.srca = 1'b1;
                e.srcb = 2'b10;
                cyc("mem_addr", e, 1'($urandom_range(0, 1)), g6(), g6());
                for (int i = 0; i <= mwaits; i++) begin
                    e      = '0;
                    e.iord = 1'b1;
                    if (op == 6'b100011) e.mrd = 1'b1;
                    else e.mwr = 1'b1;
                    cyc(op == 6'b100011 ? "mem_read" : "mem_write", e, i == mwaits, g6(), g6());
                end
                if (op == 6'b100011) begin
                    e     = '0;
                    e.rw  = 1'b1;
                    e.m2r = 2'b01;
                    cyc("mem_wb", e, 1'($urandom_range(0, 1)), g6(), g6());
                end
            end
            6'b000000: begin
                e.srca  = 1'b1;
                e.aluop = 3'b010;
                cyc("r_exec", e, 1'($urandom_range(0, 1)), g6(), fn);
                e = '0;
                if (fn == 6'b001000 || fn == 6'b001001) begin
                    e.pcw   = 1'b1;
                    e.pcsrc = 2'b11;
                    if (fn == 6'b001001) begin
                        e.rw   = 1'b1;
                        e.rdst = 2'b01;
                        e.m2r  = 2'b10;
                    end
                    cyc("jr", e, 1'($urandom_range(0, 1)), g6(), g6());
                end else begin
                    e.rw   = 1'b1;
                    e.rdst = 2'b01;
                    cyc("r_wb", e, 1'($urandom_range(0, 1)), g6(), g6());
                end
            end
            6'b000100, 6'b000101: begin
                e.srca  = 1'b1;
                e.aluop = 3'b001;
                e.pcwc  = 1'b1;
                e.pcsrc = 2'b01;
                e.bne   = (op == 6'b000101);
                cyc("branch", e, 1'($urandom_range(0, 1)), g6(), g6());
            end
            6'b000010, 6'b000011: begin
                e.pcw   = 1'b1;
                e.pcsrc = 2'b10;
                if (op == 6'b000011) begin
                    e.rw   = 1'b1;
                    e.rdst = 2'b10;
                    e.m2r  = 2'b10;
                end
                cyc(op == 6'b000011 ? "jal" : "jump", e, 1'($urandom_range(0, 1)), g6(), g6());
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
                case (op)
                    6'b001100: iop = 3'b100;
                    6'b001101: iop = 3'b101;
                    6'b001110: iop = 3'b110;
                    6'b001010: iop = 3'b011;
                    default:   iop = 3'b000;
                endcase
                e.srca  = 1'b1;
                e.srcb  = 2'b10;
                e.aluop = iop;
                cyc("i_exec", e, 1'($urandom_range(0, 1)), g6(), g6());
                e       = '0;
                e.rw    = 1'b1;
                e.aluop = iop;
                cyc("i_wb", e, 1'($urandom_range(0, 1)), g6(), g6());
            end
            default: ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw);
        do_fetch(fw);
        do_decode(op);
        do_exec(op, fn, mw);
    endtask

    initial begin
        ctl_t       e;
        logic [5:0] op, fn;

        @(negedge clk);
        do_reset();

        run_instr(6'b000000, 6'b100000, 0, 0);
        run_instr(6'b100011, 6'b000000, 0, 3);
        run_instr(6'b000101, 6'b000000, 0, 0);
        run_instr(6'b001101, 6'b000000, 1, 0);
        run_instr(6'b000011, 6'b000000, 0, 0);
        run_instr(6'b111111, 6'b000000, 0, 0);
        run_instr(6'b000000, 6'b001001, 2, 0);

        // Reset in the middle of a store wait must drop MemWrite immediately.
        do_fetch(0);
        do_decode(6'b101011);
        e      = '0;
        e.srca = 1'b1;
        e.srcb = 2'b10;
        cyc("mem_addr", e, 1'b0, g6(), g6());
        e      = '0;
        e.mwr  = 1'b1;
        e.iord = 1'b1;
        cyc("mem_write", e, 1'b0, g6(), g6());
        cyc("mem_write", e, 1'b0, g6(), g6());
        do_reset();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 11)];
            else op = g6();
            case ($urandom_range(0, 3))
                0:       fn = 6'b001000;
                1:       fn = 6'b001001;
                default: fn = g6();
            endcase
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        do_fetch(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
